// File: rtl/nibble_add_sequencer.sv
// Wide add built from one shared 4-bit add-with-carry slice, LSB nibble first.
// Latency: NIBBLES cycles from accepted start to the one-cycle done pulse.
// Backpressure: start accepted only in IDLE or DONE; requests while busy are ignored.
module nibble_add_sequencer #(
   parameter int NIBBLES = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic [4*NIBBLES-1:0] a,
   input  logic [4*NIBBLES-1:0] b,
   output logic                 busy,
   output logic                 done,
   output logic [4*NIBBLES-1:0] sum,
   output logic                 cout
);
   localparam int W    = 4 * NIBBLES;
   localparam int IDXW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
   localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NIBBLES - 1);

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } state_t;

   state_t          state;
   state_t          state_nxt;
   logic [W-1:0]    op_a;
   logic [W-1:0]    op_b;
   logic [W-1:0]    partial;
   logic [W-1:0]    merged;
   logic [IDXW-1:0] idx;
   logic            carry;
   logic            accept;
   logic            last;
   logic [3:0]      nib_a;
   logic [3:0]      nib_b;
   logic [4:0]      slice;

   // Shared 4-bit slice on the current nibble, plus the partial sum with that nibble merged in.
   always_comb begin
      nib_a  = op_a[{idx, 2'b00} +: 4];
      nib_b  = op_b[{idx, 2'b00} +: 4];
      slice  = {1'b0, nib_a} + {1'b0, nib_b} + {4'b0000, carry};
      last   = (idx == LAST_IDX);
      merged = partial;
      merged[{idx, 2'b00} +: 4] = slice[3:0];
   end

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state and status outputs; DONE doubles as an accept slot for back-to-back ops.
   always_comb begin
      state_nxt = state;
      busy      = 1'b0;
      done      = 1'b0;
      accept    = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               accept    = 1'b1;
               state_nxt = RUN;
            end
         end
         RUN: begin
            busy = 1'b1;
            if (last) begin
               state_nxt = DONE;
            end
         end
         DONE: begin
            done = 1'b1;
            if (start) begin
               accept    = 1'b1;
               state_nxt = RUN;
            end else begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Operand capture, nibble walk, and publishing of the result only on the final nibble.
   always_ff @(posedge clk) begin
      if (rst) begin
         op_a    <= '0;
         op_b    <= '0;
         partial <= '0;
         carry   <= 1'b0;
         idx     <= '0;
         sum     <= '0;
         cout    <= 1'b0;
      end else if (accept) begin
         op_a    <= a;
         op_b    <= b;
         partial <= '0;
         carry   <= 1'b0;
         idx     <= '0;
      end else if (state == RUN) begin
         partial <= merged;
         carry   <= slice[4];
         idx     <= idx + 1'b1;
         if (last) begin
            sum  <= merged;
            cout <= slice[4];
         end
      end
   end

endmodule

// File: tb/tb_nibble_add_sequencer.sv
// Bench for nibble_add_sequencer: directed scenarios plus random operands.
// Expected results come from a plain wide addition, never from the nibble walk.
// Inputs driven and outputs sampled on the falling clock edge.
module tb_nibble_add_sequencer;
   localparam int NIB = 4;
   localparam int W   = 4 * NIB;

   logic         clk;
   logic         rst;
   logic         start;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         busy;
   logic         done;
   logic [W-1:0] sum;
   logic         cout;

   int           checks = 0;
   int           errors = 0;
   logic [W-1:0] exp_sum;
   logic         exp_cout;

   nibble_add_sequencer #(.NIBBLES(NIB)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .a     (a),
      .b     (b),
      .busy  (busy),
      .done  (done),
      .sum   (sum),
      .cout  (cout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   // Idle cycles: nothing running, outputs hold the last result.
   task automatic idle(input int n);
      start = 1'b0;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         chk("idle_busy", busy, 1'b0);
         chk("idle_done", done, 1'b0);
         chk("idle_sum", sum, exp_sum);
         chk("idle_cout", cout, exp_cout);
      end
   endtask

   // One operation: start at the current falling edge, random noise on inputs while
   // running (must be ignored), returns at the falling edge of the DONE cycle.
   task automatic op(input logic [W-1:0] xa, input logic [W-1:0] xb, input bit poke);
      logic [W:0] r;
      r     = {1'b0, xa} + {1'b0, xb};
      start = 1'b1;
      a     = xa;
      b     = xb;
      @(negedge clk);
      for (int k = 0; k < NIB; k++) begin
         if (poke && k == 1) begin
            start = 1'b1;
            a     = '1;
            b     = '1;
         end else begin
            start = 1'($urandom_range(0, 1));
            a     = W'($urandom);
            b     = W'($urandom);
         end
         chk("run_busy", busy, 1'b1);
         chk("run_done", done, 1'b0);
         chk("run_hold_sum", sum, exp_sum);
         chk("run_hold_cout", cout, exp_cout);
         @(negedge clk);
      end
      exp_sum  = r[W-1:0];
      exp_cout = r[W];
      chk("done_pulse", done, 1'b1);
      chk("done_busy", busy, 1'b0);
      chk("done_sum", sum, exp_sum);
      chk("done_cout", cout, exp_cout);
      start = 1'b0;
   endtask

   initial begin
      logic [W-1:0] ra;
      logic [W-1:0] rb;

      // Reset held two cycles with start asserted: nothing may be accepted.
      rst      = 1'b1;
      start    = 1'b1;
      a        = 16'h1234;
      b        = 16'h4321;
      exp_sum  = '0;
      exp_cout = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_busy", busy, 1'b0);
      chk("rst_done", done, 1'b0);
      chk("rst_sum", sum, 16'h0000);
      chk("rst_cout", cout, 1'b0);
      rst = 1'b0;
      idle(2);

      // Simple add.
      op(16'h000A, 16'h0002, 1'b0);
      chk("t2_sum", sum, 16'h000C);
      chk("t2_cout", cout, 1'b0);
      idle(1);

      // Full ripple through every nibble.
      op(16'hFFFF, 16'h0001, 1'b0);
      chk("t3_sum", sum, 16'h0000);
      chk("t3_cout", cout, 1'b1);
      idle(1);

      // Start while busy is ignored: exactly one done pulse.
      op(16'h1234, 16'h1111, 1'b1);
      chk("t4_sum", sum, 16'h2345);
      chk("t4_cout", cout, 1'b0);
      idle(3);

      // Back-to-back: second start during the first DONE cycle.
      op(16'h00FF, 16'h0001, 1'b0);
      chk("t5a_sum", sum, 16'h0100);
      op(16'h8000, 16'h8000, 1'b0);
      chk("t5b_sum", sum, 16'h0000);
      chk("t5b_cout", cout, 1'b1);
      idle(1);

      // Reset in RUN cycle 3 aborts the operation.
      start = 1'b1;
      a     = 16'h0F0F;
      b     = 16'h0101;
      @(negedge clk);
      start = 1'b0;
      chk("t6_run1_busy", busy, 1'b1);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst      = 1'b0;
      exp_sum  = '0;
      exp_cout = 1'b0;
      chk("t6_busy", busy, 1'b0);
      chk("t6_done", done, 1'b0);
      chk("t6_sum", sum, 16'h0000);
      chk("t6_cout", cout, 1'b0);
      idle(5);
      op(16'h0003, 16'h0004, 1'b0);
      chk("t6_next_sum", sum, 16'h0007);
      idle(1);

      // Random operands, mixing back-to-back and spaced operations.
      for (int n = 0; n < 40; n++) begin
         ra = W'($urandom);
         rb = W'($urandom);
         if ($urandom_range(0, 7) == 0) ra = '1;
         op(ra, rb, 1'($urandom_range(0, 1)));
         if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 3));
      end
      idle(2);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/nibble_add_sequencer.md
# nibble_add_sequencer

Multi-cycle controller that computes a wide sum with a single 4-bit add-with-carry slice. It adds one nibble per clock, from least significant to most significant, and keeps the inter-nibble carry in a register. The block sits between a requester issuing wide add operations and the shared 4-bit adder datapath. It trades latency (NIBBLES cycles) for reuse of one narrow adder.

## Interface

Parameters:
- NIBBLES, default 4: operand width in nibbles. Operand width W = 4*NIBBLES. Legal range 1..16.

Ports:
- clk  in  1  single clock; all state changes on rising edge
- rst  in  1  reset, synchronous, active-high
- start  in  1  request; operands captured when accepted
- a  in  W  operand A, sampled only on accepted start
- b  in  W  operand B, sampled only on accepted start
- busy  out  1  high while a computation is in progress (state RUN)
- done  out  1  one-cycle pulse: result valid
- sum  out  W  registered result; holds until next completion
- cout  out  1  carry out of MSB nibble; registered with sum

## Operation

States: IDLE, RUN, DONE.

IDLE:
- busy=0, done=0.
- start=1 → latch a, b into operand registers; clear carry register; clear nibble index idx to 0; clear the partial-sum register; go to RUN.
- start=0 → stay in IDLE.

RUN (busy=1):
- Each cycle, the slice computes {c_next, s} = a[4*idx+3:4*idx] + b[4*idx+3:4*idx] + carry, a 5-bit result.
- s is written into partial-sum nibble idx; carry <= c_next; idx <= idx+1.
- When idx == NIBBLES-1:
  - sum <= partial with the final nibble merged in.
  - cout <= c_next.
  - go to DONE.
- start is ignored in RUN. Operand registers must not change.

DONE (busy=0, done=1 for exactly this cycle):
- start=1 → accept new operation exactly as from IDLE (back-to-back), go to RUN.
- start=0 → go to IDLE.

General rules:
- sum and cout change only on the final RUN edge. They are never partially updated at the outputs.
- Arithmetic is modulo 2^W; the overflow bit goes to cout only.
- idx width is ceil(log2(NIBBLES)), minimum 1 bit.
- NIBBLES=1: a single RUN cycle.

## Timing

- Reset (rst=1 at an edge) forces: state IDLE, busy=0, done=0, sum=0, cout=0, carry=0, idx=0.
- Reset has priority over start and over any in-flight RUN.
- Reset mid-RUN aborts the operation: no done pulse, sum and cout go to 0.
- Latency: start sampled at edge E0.
  - busy=1 after E0 through edge E_NIBBLES.
  - done=1 and sum/cout valid in the cycle after edge E_NIBBLES, i.e. NIBBLES cycles after acceptance.
- Throughput: one result per NIBBLES+1 cycles with back-to-back starts asserted in DONE.
- start held high continuously yields a new operation accepted every DONE cycle, with operands re-sampled each time.

## Test plan

Scenarios use NIBBLES=4 (W=16).

1. Reset state: assert rst for 2 cycles with start=1 → busy=0, done=0, sum=0x0000, cout=0; no operation is accepted while rst=1.
2. Simple add: a=0x000A, b=0x0002, start pulse one cycle → busy=1 for 4 cycles, then done=1 for 1 cycle, sum=0x000C, cout=0.
3. Full ripple: a=0xFFFF, b=0x0001 → sum=0x0000, cout=1, done 4 cycles after the start edge.
4. Start while busy:
   - a=0x1234, b=0x1111 accepted.
   - In RUN cycle 2, assert start with a=0xFFFF, b=0xFFFF.
   - Required: exactly one done pulse, with sum=0x2345, cout=0.
5. Back-to-back:
   - First operation a=0x00FF, b=0x0001 → sum=0x0100.
   - start=1 during its DONE cycle with a=0x8000, b=0x8000 → second done exactly 5 cycles after the first, with sum=0x0000, cout=1.
   - First result is held until the second completes.
6. Reset mid-operation:
   - rst=1 in RUN cycle 3 of a=0x0F0F, b=0x0101 → no done, sum=0, cout=0, busy=0.
   - A following operation a=0x0003, b=0x0004 yields sum=0x0007.
